// File: rtl/mdu_pkg.sv
// Shared MDU constants: op encodings, default latencies, and the divide helper
// used by the datapath (and by the instruction decoder).
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Returns {remainder, quotient}. Works on magnitudes so that signed
    // truncation and the 0x80000000 / -1 overflow case fall out naturally.
    function automatic logic [63:0] divmod(input mdu_op_e op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic        neg_a, neg_b;
        logic [31:0] ma, mb, q, r;
        neg_a = (op == OP_DIV) && a[31];
        neg_b = (op == OP_DIV) && b[31];
        ma    = neg_a ? (~a + 32'd1) : a;
        mb    = neg_b ? (~b + 32'd1) : b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = ma / mb;
            r = ma % mb;
            if (neg_a ^ neg_b) q = ~q + 32'd1;
            if (neg_a)         r = ~r + 32'd1;
        end
        return {r, q};
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Results are combinational from
// latched operands; a down-counter models the multi-cycle latency.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    mdu_op_e          op_q, op_n;
    logic [31:0]      a_q, a_n, b_q, b_n;
    logic [31:0]      hi_n, lo_n;
    logic [63:0]      prod, res;
    mdu_op_e          req_op;

    assign req_op = mdu_op_e'(mdu_op);

    // 64-bit multiply of sign/zero-extended operands gives the right low 64 bits.
    always_comb begin
        if (op_q == OP_MULT)
            prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        else
            prod = {32'd0, a_q} * {32'd0, b_q};
        if (op_q == OP_MULT || op_q == OP_MULTU)
            res = prod;
        else
            res = divmod(op_q, a_q, b_q);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi;
        lo_n    = lo;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (req_op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_n = S_BUSY;
                            op_n    = req_op;
                            a_n     = op1;
                            b_n     = op2;
                            cnt_n   = (req_op == OP_MULT || req_op == OP_MULTU)
                                      ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        end
                        OP_MTHI: hi_n = op1;
                        OP_MTLO: lo_n = op1;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // start is deliberately not looked at here, including the last cycle
                if (cnt <= CNT_W'(1)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    hi_n    = res[63:32];
                    lo_n    = res[31:0];
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

    assign busy = (state == S_BUSY);

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latency, results, hazards and reset.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] op1, op2;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int errors  = 0;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        mdu_op = op;
        op1    = a;
        op2    = b;
        tick();
        start  = 1'b0;
    endtask

    // Counts busy cycles after issue; bounded so a stuck busy cannot hang the run.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mdu_op = 3'd0; op1 = '0; op2 = '0;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        int n;
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        op1 = 32'h1111_1111; op2 = 32'h3333_3333;
        n = 0;
        while (busy && n < 50) begin
            n++;
            vectors++;
            if (hi !== 32'd0 || lo !== 32'd0) begin
                errors++;
                $display("FAIL mult_hold: cycle %0d hi=%h lo=%h, want 0/0", n, hi, lo);
            end
            tick();
        end
        vectors++;
        if (n != 5) begin
            errors++;
            $display("FAIL mult_latency: got %0d busy cycles, want 5", n);
        end
        vectors++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mult_result: hi=%h lo=%h, want ffffffff/fffffffe", hi, lo);
        end
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done(n);
        vectors++;
        if (n != 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_result: n=%0d hi=%h lo=%h, want 5 00000001/fffffffe", n, hi, lo);
        end
    endtask

    task automatic test_div();
        int n;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        op1 = 32'd100; op2 = 32'd3;
        wait_done(n);
        vectors++;
        if (n != 10) begin
            errors++;
            $display("FAIL div_latency: got %0d busy cycles, want 10", n);
        end
        vectors++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_signed: hi=%h lo=%h, want ffffffff/fffffffd", hi, lo);
        end
        issue(3'd3, 32'd7, 32'd0);
        wait_done(n);
        vectors++;
        if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_by_zero: hi=%h lo=%h, want 00000007/ffffffff", hi, lo);
        end
        issue(3'd2, 32'hFFFF_FFF9, 32'd0);
        wait_done(n);
        vectors++;
        if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_by_zero: hi=%h lo=%h, want fffffff9/ffffffff", hi, lo);
        end
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow: hi=%h lo=%h, want 00000000/80000000", hi, lo);
        end
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        vectors++;
        if (hi !== 32'd1 || lo !== 32'h7FFF_FFFC) begin
            errors++;
            $display("FAIL divu_result: hi=%h lo=%h, want 00000001/7ffffffc", hi, lo);
        end
    endtask

    task automatic test_mt_in_busy();
        int n;
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (n == 2) begin
                start = 1'b1; mdu_op = 3'd5; op1 = 32'h1234;
            end
            tick();
            start = 1'b0;
        end
        vectors++;
        if (n != 5 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mtlo_in_busy: n=%0d hi=%h lo=%h, want 5 ffffffff/fffffffe", n, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(3'd1, 32'd3, 32'd5);
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (n == 5) begin
                start = 1'b1; mdu_op = 3'd4; op1 = 32'hAAAA;
            end
            tick();
            start = 1'b0;
        end
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd15) begin
            errors++;
            $display("FAIL start_on_completion: busy=%b hi=%h lo=%h, want 0 00000000/0000000f", busy, hi, lo);
        end
        issue(3'd5, 32'h5555, 32'd0);
        vectors++;
        if (busy !== 1'b0 || lo !== 32'h5555 || hi !== 32'd0) begin
            errors++;
            $display("FAIL mtlo_after_completion: busy=%b hi=%h lo=%h, want 0 00000000/00005555", busy, hi, lo);
        end
    endtask

    task automatic test_mthi_nop();
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        vectors++;
        if (busy !== 1'b0 || hi !== 32'hDEAD_BEEF || lo !== 32'h5555) begin
            errors++;
            $display("FAIL mthi: busy=%b hi=%h lo=%h, want 0 deadbeef/00005555", busy, hi, lo);
        end
        issue(3'd6, 32'h0BAD_0BAD, 32'd1);
        issue(3'd7, 32'h0BAD_0BAD, 32'd1);
        start = 1'b0; mdu_op = 3'd4; op1 = 32'h0BAD_0BAD;
        tick();
        vectors++;
        if (busy !== 1'b0 || hi !== 32'hDEAD_BEEF || lo !== 32'h5555) begin
            errors++;
            $display("FAIL nop_no_change: busy=%b hi=%h lo=%h, want 0 deadbeef/00005555", busy, hi, lo);
        end
    endtask

    task automatic test_reset_abort();
        issue(3'd2, 32'd100, 32'd7);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                errors++;
                $display("FAIL reset_abort_hold: cycle %0d busy=%b hi=%h lo=%h, want 0/0/0", i, busy, hi, lo);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue(3'd4, 32'hCAFE_F00D, 32'd0);
        vectors++;
        if (hi !== 32'hCAFE_F00D || lo !== 32'd0) begin
            errors++;
            $display("FAIL accept_after_reset: hi=%h lo=%h, want cafef00d/00000000", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_in_busy();
        test_back_to_back();
        test_mthi_nop();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
